// File: rtl/issue_queue_int_pkg.sv
// Shared types and sizing for the integer issue path.
package issue_queue_int_pkg;

    localparam int IQ_DISPATCH_WIDTH  = 4;
    localparam int IQ_ISSUE_WIDTH_INT = 2;
    localparam int IQ_WAKEUP_WIDTH    = 4;
    localparam int PRF_INDEX_SIZE     = 7;

    typedef struct packed {
        logic                      valid;
        logic [5:0]                opcode;
        logic                      rd_valid;
        logic [PRF_INDEX_SIZE-1:0] rd_p;
        logic                      rs1_valid;
        logic [PRF_INDEX_SIZE-1:0] rs1_p;
        logic                      rs2_valid;
        logic [PRF_INDEX_SIZE-1:0] rs2_p;
        logic [31:0]               imm;
        logic [5:0]                rob_idx;
    } micro_op_t;

endpackage

// File: rtl/issue_queue_int_select.sv
// Oldest-first picker: each enabled port, in ascending order, grabs the
// lowest-index remaining candidate. Shared by the int/mem/fp issue queues.
module iq_select #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_PORTS   = 2
) (
    input  logic [NUM_ENTRIES-1:0]                candidate_i,
    input  logic [NUM_PORTS-1:0]                  fu_ready_i,
    output logic [NUM_PORTS-1:0][NUM_ENTRIES-1:0] grant_o,
    output logic [NUM_PORTS-1:0]                  grant_valid_o
);

    // Walk ports in order, removing each granted entry from the pool
    always_comb begin
        logic [NUM_ENTRIES-1:0] remaining;
        logic                   found;
        remaining     = candidate_i;
        grant_o       = '0;
        grant_valid_o = '0;
        found         = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            found = 1'b0;
            if (fu_ready_i[k]) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (!found && remaining[i]) begin
                        grant_o[k][i] = 1'b1;
                        remaining[i]  = 1'b0;
                        found         = 1'b1;
                    end
                end
            end
            grant_valid_o[k] = found;
        end
    end

endmodule

// File: rtl/issue_queue_int.sv
// Integer issue queue: collapsing age-ordered buffer, tag wakeup,
// oldest-ready selection onto registered issue ports.
module issue_queue_int
    import issue_queue_int_pkg::*;
#(
    parameter int IQ_SIZE        = 16,
    parameter int DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH    = IQ_ISSUE_WIDTH_INT,
    parameter int WAKEUP_WIDTH   = IQ_WAKEUP_WIDTH,
    parameter int PRF_IDX_W      = PRF_INDEX_SIZE
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  micro_op_t [DISPATCH_WIDTH-1:0]        uop_in,
    output logic                                  ready_out,
    input  logic [WAKEUP_WIDTH-1:0]               wakeup_valid,
    input  logic [WAKEUP_WIDTH-1:0][PRF_IDX_W-1:0] wakeup_tag,
    input  logic [ISSUE_WIDTH-1:0]                fu_ready,
    output micro_op_t [ISSUE_WIDTH-1:0]           uop_out,
    input  logic                                  flush,
    output logic [$clog2(IQ_SIZE+1)-1:0]          count
);

    localparam int CNT_W = $clog2(IQ_SIZE + 1);
    localparam logic [CNT_W-1:0] ACCEPT_LIMIT = CNT_W'(IQ_SIZE - DISPATCH_WIDTH);

    logic [IQ_SIZE-1:0]                 entryValid_q, entryValid_d;
    logic [IQ_SIZE-1:0]                 rdy1_q, rdy1_d;
    logic [IQ_SIZE-1:0]                 rdy2_q, rdy2_d;
    micro_op_t [IQ_SIZE-1:0]            entryUop_q, entryUop_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    micro_op_t [ISSUE_WIDTH-1:0]        uopOut_q, uopOut_d;

    logic [IQ_SIZE-1:0]                 candidate;
    logic [IQ_SIZE-1:0]                 issued;
    logic [ISSUE_WIDTH-1:0][IQ_SIZE-1:0] grant;
    logic [ISSUE_WIDTH-1:0]             grantValid;
    logic                               accept;
    logic                               anyInValid;

    function automatic logic tagHit(
        input logic [PRF_IDX_W-1:0]                  tag,
        input logic [WAKEUP_WIDTH-1:0]               wv,
        input logic [WAKEUP_WIDTH-1:0][PRF_IDX_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < WAKEUP_WIDTH; j++) begin
            if (wv[j] && (wt[j] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign ready_out = (count_q <= ACCEPT_LIMIT);
    assign accept    = ready_out && !flush;
    assign candidate = entryValid_q & rdy1_q & rdy2_q;
    assign uop_out   = uopOut_q;
    assign count     = count_q;

    iq_select #(
        .NUM_ENTRIES (IQ_SIZE),
        .NUM_PORTS   (ISSUE_WIDTH)
    ) u_select (
        .candidate_i   (candidate),
        .fu_ready_i    (fu_ready),
        .grant_o       (grant),
        .grant_valid_o (grantValid)
    );

    // Union of all port grants marks the entries leaving the buffer this cycle
    always_comb begin
        issued = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            issued = issued | grant[k];
        end
    end

    // Collapse survivors toward index 0, then append accepted uops behind them
    always_comb begin
        int srcRank [IQ_SIZE];
        int inRank  [DISPATCH_WIDTH];
        int survivors;
        int accepted;
        entryValid_d = '0;
        rdy1_d       = '0;
        rdy2_d       = '0;
        entryUop_d   = '0;
        survivors    = 0;
        accepted     = 0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            srcRank[i] = survivors;
            if (entryValid_q[i] && !issued[i]) begin
                survivors = survivors + 1;
            end
        end
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            inRank[s] = accepted;
            if (accept && uop_in[s].valid) begin
                accepted = accepted + 1;
            end
        end
        for (int d = 0; d < IQ_SIZE; d++) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (entryValid_q[i] && !issued[i] && (srcRank[i] == d)) begin
                    entryValid_d[d] = 1'b1;
                    entryUop_d[d]   = entryUop_q[i];
                    rdy1_d[d]       = rdy1_q[i] || tagHit(entryUop_q[i].rs1_p, wakeup_valid, wakeup_tag);
                    rdy2_d[d]       = rdy2_q[i] || tagHit(entryUop_q[i].rs2_p, wakeup_valid, wakeup_tag);
                end
            end
            for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                if (accept && uop_in[s].valid && ((survivors + inRank[s]) == d)) begin
                    entryValid_d[d] = 1'b1;
                    entryUop_d[d]   = uop_in[s];
                    rdy1_d[d]       = !uop_in[s].rs1_valid || (uop_in[s].rs1_p == '0) ||
                                      tagHit(uop_in[s].rs1_p, wakeup_valid, wakeup_tag);
                    rdy2_d[d]       = !uop_in[s].rs2_valid || (uop_in[s].rs2_p == '0) ||
                                      tagHit(uop_in[s].rs2_p, wakeup_valid, wakeup_tag);
                end
            end
        end
        count_d = CNT_W'(survivors + accepted);
        if (flush) begin
            entryValid_d = '0;
            rdy1_d       = '0;
            rdy2_d       = '0;
            entryUop_d   = '0;
            count_d      = '0;
        end
    end

    // Route each granted entry to its port; idle ports present all-zero
    always_comb begin
        uopOut_d = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (!flush && grantValid[k] && grant[k][i]) begin
                    uopOut_d[k] = entryUop_q[i];
                end
            end
        end
    end

    // Register buffer state, occupancy and issue ports
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entryValid_q <= '0;
            rdy1_q       <= '0;
            rdy2_q       <= '0;
            entryUop_q   <= '0;
            count_q      <= '0;
            uopOut_q     <= '0;
        end else begin
            entryValid_q <= entryValid_d;
            rdy1_q       <= rdy1_d;
            rdy2_q       <= rdy2_d;
            entryUop_q   <= entryUop_d;
            count_q      <= count_d;
            uopOut_q     <= uopOut_d;
        end
    end

    // Collect slot valids so a dispatch into a full queue can be flagged
    always_comb begin
        anyInValid = 1'b0;
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            anyInValid = anyInValid | uop_in[s].valid;
        end
    end

    dispatchWhileFull: assert property (@(posedge clock) disable iff (!reset_n)
        !(anyInValid && !ready_out));

endmodule
